dlx_mem_responder: RTL and testbench

//  Memory-side responder for the uDLX core's instruction and data bus initiator ports.
//  - Instruction port: read-only, 1-cycle read latency.
//  - Data port: read/write, 1-cycle read latency.
//  - Host load port: fills both memories while the core is held in reset, then releases it.

---
 rtl/dlx_mem_responder.sv | 140 ++++++++++++++
 tb/tb_dlx_mem_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dlx_mem_responder.sv
// Memory-side responder for the uDLX core: instruction and data memories,
// plus a host load port that fills both while the core is held in reset.
module dlx_mem_responder #(
  parameter int                   DATA_WIDTH      = 32,
  parameter int                   INST_ADDR_WIDTH = 20,
  parameter int                   DATA_ADDR_WIDTH = 32,
  parameter int                   IMEM_AW         = 10,
  parameter int                   DMEM_AW         = 10,
  parameter logic [INST_ADDR_WIDTH-1:0] INST_BASE = 20'h40000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       instr_rd_en,
  input  logic [INST_ADDR_WIDTH-1:0] instr_addr,
  output logic [DATA_WIDTH-1:0]      instruction,
  input  logic                       data_rd_en,
  input  logic                       data_wr_en,
  input  logic [DATA_ADDR_WIDTH-1:0] data_addr,
  input  logic [DATA_WIDTH-1:0]      data_write,
  output logic [DATA_WIDTH-1:0]      data_read,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic                       load_sel,
  input  logic [15:0]                load_addr,
  input  logic [DATA_WIDTH-1:0]      load_data,
  input  logic                       load_done,
  input  logic                       halt_req,
  output logic                       core_rst_n,
  output logic                       addr_err
);

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] instruction_q;
  logic [DATA_WIDTH-1:0] data_read_q;
  logic                  core_rst_n_q;
  logic                  load_ready_q;
  logic                  addr_err_q;

  logic [DATA_WIDTH-1:0] imem [2**IMEM_AW];
  logic [DATA_WIDTH-1:0] dmem [2**DMEM_AW];

  logic [INST_ADDR_WIDTH-1:0] inst_off;
  logic [IMEM_AW-1:0]         inst_idx;
  logic                       inst_oor;
  logic [DMEM_AW-1:0]         data_idx;
  logic                       data_oor;
  logic                       running;
  logic                       inst_rd;
  logic                       data_rd;
  logic                       data_wr;
  logic                       host_wr;
  logic                       err_set;
  logic                       unused_bits;

  // Instruction addresses are relative to the core reset PC; the subtraction
  // wraps, so addresses below INST_BASE land far out of range.
  assign inst_off = instr_addr - INST_BASE;
  assign inst_idx = inst_off[IMEM_AW+1:2];
  assign inst_oor = |inst_off[INST_ADDR_WIDTH-1:IMEM_AW+2];
  assign data_idx = data_addr[DMEM_AW+1:2];
  assign data_oor = |data_addr[DATA_ADDR_WIDTH-1:DMEM_AW+2];

  assign running = (state_q == RUN);
  assign inst_rd = running & instr_rd_en;
  assign data_rd = running & data_rd_en;
  assign data_wr = running & data_wr_en & ~data_oor;
  assign host_wr = load_valid & load_ready_q;
  assign err_set = (inst_rd & inst_oor) |
                   (running & (data_rd_en | data_wr_en) & data_oor);

  assign unused_bits = ^{load_addr[15:IMEM_AW], load_addr[15:DMEM_AW],
                         inst_off[1:0], data_addr[1:0]};

  // halt_req has priority over load_done in either state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (load_done && !halt_req) state_d = RUN;
      RUN:     if (halt_req)               state_d = LOAD;
      default:                             state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LOAD;
      instruction_q <= '0;
      data_read_q   <= '0;
      core_rst_n_q  <= 1'b0;
      load_ready_q  <= 1'b0;
      addr_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_ready_q <= (state_d == LOAD);
      // Release the core one cycle after entering RUN, but drop it on the halt edge.
      core_rst_n_q <= running && (state_d == RUN);

      if (running && state_d == LOAD) begin
        addr_err_q <= 1'b0;
      end else if (err_set) begin
        addr_err_q <= 1'b1;
      end

      if (inst_rd) begin
        instruction_q <= inst_oor ? '0 : imem[inst_idx];
      end
      if (data_rd) begin
        data_read_q <= data_oor ? '0 : dmem[data_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (host_wr && !load_sel) begin
      imem[load_addr[IMEM_AW-1:0]] <= load_data;
    end
  end

  // Host and core writes never coincide: load_ready is only high in LOAD.
  always_ff @(posedge clk) begin
    if (host_wr && load_sel) begin
      dmem[load_addr[DMEM_AW-1:0]] <= load_data;
    end else if (data_wr) begin
      dmem[data_idx] <= data_write;
    end
  end

  assign instruction = instruction_q;
  assign data_read   = data_read_q;
  assign core_rst_n  = core_rst_n_q;
  assign load_ready  = load_ready_q;
  assign addr_err    = addr_err_q;

endmodule

// File: tb/tb_dlx_mem_responder.sv
// Table-driven bench for dlx_mem_responder: one vector per clock cycle,
// plus a hand-written asynchronous reset sequence in the middle of RUN.
module tb_dlx_mem_responder;

  logic        clk;
  logic        rst_n;
  logic        instr_rd_en;
  logic [19:0] instr_addr;
  logic [31:0] instruction;
  logic        data_rd_en;
  logic        data_wr_en;
  logic [31:0] data_addr;
  logic [31:0] data_write;
  logic [31:0] data_read;
  logic        load_valid;
  logic        load_ready;
  logic        load_sel;
  logic [15:0] load_addr;
  logic [31:0] load_data;
  logic        load_done;
  logic        halt_req;
  logic        core_rst_n;
  logic        addr_err;

  int checkCount = 0;
  int failCount  = 0;

  typedef struct {
    logic        lv;
    logic        lsel;
    logic [15:0] laddr;
    logic [31:0] ldata;
    logic        ldone;
    logic        halt;
    logic        ird;
    logic [19:0] iaddr;
    logic        drd;
    logic        dwr;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] eInstr;
    logic [31:0] eData;
    logic        eCrst;
    logic        eRdy;
    logic        eErr;
  } vec_t;

  vec_t tbl[$];

  dlx_mem_responder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_rd_en (instr_rd_en),
    .instr_addr  (instr_addr),
    .instruction (instruction),
    .data_rd_en  (data_rd_en),
    .data_wr_en  (data_wr_en),
    .data_addr   (data_addr),
    .data_write  (data_write),
    .data_read   (data_read),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_sel    (load_sel),
    .load_addr   (load_addr),
    .load_data   (load_data),
    .load_done   (load_done),
    .halt_req    (halt_req),
    .core_rst_n  (core_rst_n),
    .addr_err    (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic lv, input logic lsel, input logic [15:0] laddr, input logic [31:0] ldata,
    input logic ldone, input logic halt,
    input logic ird, input logic [19:0] iaddr,
    input logic drd, input logic dwr, input logic [31:0] daddr, input logic [31:0] dwdata,
    input logic [31:0] eInstr, input logic [31:0] eData,
    input logic eCrst, input logic eRdy, input logic eErr);
    vec_t v;
    v.lv = lv;  v.lsel = lsel;  v.laddr = laddr;  v.ldata = ldata;
    v.ldone = ldone;  v.halt = halt;
    v.ird = ird;  v.iaddr = iaddr;
    v.drd = drd;  v.dwr = dwr;  v.daddr = daddr;  v.dwdata = dwdata;
    v.eInstr = eInstr;  v.eData = eData;
    v.eCrst = eCrst;  v.eRdy = eRdy;  v.eErr = eErr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drive one cycle's inputs on the falling edge, then sample 1ns after the rising edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    load_valid  = v.lv;
    load_sel    = v.lsel;
    load_addr   = v.laddr;
    load_data   = v.ldata;
    load_done   = v.ldone;
    halt_req    = v.halt;
    instr_rd_en = v.ird;
    instr_addr  = v.iaddr;
    data_rd_en  = v.drd;
    data_wr_en  = v.dwr;
    data_addr   = v.daddr;
    data_write  = v.dwdata;
    @(posedge clk);
    #1;
  endtask

  task automatic checkVector(input string tag, input vec_t v);
    checkOutput({tag, " instruction"}, instruction, v.eInstr);
    checkOutput({tag, " data_read"},   data_read,   v.eData);
    checkOutput({tag, " core_rst_n"},  {31'b0, core_rst_n}, {31'b0, v.eCrst});
    checkOutput({tag, " load_ready"},  {31'b0, load_ready}, {31'b0, v.eRdy});
    checkOutput({tag, " addr_err"},    {31'b0, addr_err},   {31'b0, v.eErr});
  endtask

  task automatic runVector(input string tag, input vec_t v);
    applyStimulus(v);
    checkVector(tag, v);
  endtask

  initial begin
    vec_t zeroVec;
    rst_n = 1'b0;
    load_valid = 0; load_sel = 0; load_addr = '0; load_data = '0;
    load_done = 0; halt_req = 0;
    instr_rd_en = 0; instr_addr = '0;
    data_rd_en = 0; data_wr_en = 0; data_addr = '0; data_write = '0;

    zeroVec = mk(0,0,0,0, 0,0, 0,0, 0,0,0,0, 32'h0, 32'h0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkVector("reset", zeroVec);
    @(negedge clk);
    rst_n = 1'b1;

    //           lv sel addr  data        dn ht ird iaddr      drd dwr daddr    wdata        eInstr      eData        C  R  E
    tbl.push_back(mk(0,0,16'h0,32'h0,       0,0, 0,20'h0,     0,0,32'h0,   32'h0,       32'h0,      32'h0,       0,1,0));
    tbl.push_back(mk(1,0,16'h0,32'h11,      0,0, 0,20'h0,     0,0,32'h0,   32'h0,       32'h0,      32'h0,       0,1,0));
    tbl.push_back(mk(1,0,16'h1,32'h22,      0,0, 0,20'h0,     0,0,32'h0,   32'h0,       32'h0,      32'h0,       0,1,0));
    tbl.push_back(mk(1,0,16'h2,32'h33,      0,0, 0,20'h0,     0,0,32'h0,   32'h0,       32'h0,      32'h0,       0,1,0));
    tbl.push_back(mk(1,0,16'h3,32'h44,      0,0, 0,20'h0,     0,0,32'h0,   32'h0,       32'h0,      32'h0,       0,1,0));
    tbl.push_back(mk(1,1,16'h8,32'h5,       0,0, 0,20'h0,     0,0,32'h0,   32'h0,       32'h0,      32'h0,       0,1,0));
    tbl.push_back(mk(0,0,16'h0,32'h0,       1,0, 0,20'h0,     0,0,32'h0,   32'h0,       32'h0,      32'h0,       0,0,0));
    tbl.push_back(mk(0,0,16'h0,32'h0,       0,0, 0,20'h0,     0,0,32'h0,   32'h0,       32'h0,      32'h0,       1,0,0));
    tbl.push_back(mk(0,0,16'h0,32'h0,       0,0, 1,20'h40008, 0,0,32'h0,   32'h0,       32'h33,     32'h0,       1,0,0));
    tbl.push_back(mk(0,0,16'h0,32'h0,       0,0, 0,20'h40000, 0,0,32'h0,   32'h0,       32'h33,     32'h0,       1,0,0));
    tbl.push_back(mk(0,0,16'h0,32'h0,       0,0, 0,20'h0,     0,1,32'h10,  32'hDEADBEEF,32'h33,     32'h0,       1,0,0));
    tbl.push_back(mk(0,0,16'h0,32'h0,       0,0, 0,20'h0,     1,0,32'h12,  32'h0,       32'h33,     32'hDEADBEEF,1,0,0));
    tbl.push_back(mk(0,0,16'h0,32'h0,       0,0, 0,20'h0,     0,0,32'h20,  32'h0,       32'h33,     32'hDEADBEEF,1,0,0));
    tbl.push_back(mk(0,0,16'h0,32'h0,       0,0, 0,20'h0,     1,1,32'h20,  32'h9,       32'h33,     32'h5,       1,0,0));
    tbl.push_back(mk(0,0,16'h0,32'h0,       0,0, 0,20'h0,     1,0,32'h20,  32'h0,       32'h33,     32'h9,       1,0,0));
    tbl.push_back(mk(0,0,16'h0,32'h0,       0,0, 1,20'h40004, 0,0,32'h0,   32'h0,       32'h22,     32'h9,       1,0,0));
    tbl.push_back(mk(1,1,16'h4,32'hBAD,     0,0, 0,20'h0,     0,0,32'h0,   32'h0,       32'h22,     32'h9,       1,0,0));
    tbl.push_back(mk(0,0,16'h0,32'h0,       0,0, 0,20'h0,     1,0,32'h10,  32'h0,       32'h22,     32'hDEADBEEF,1,0,0));
    tbl.push_back(mk(1,0,16'h2,32'hFFFF,    0,0, 0,20'h0,     0,0,32'h0,   32'h0,       32'h22,     32'hDEADBEEF,1,0,0));
    tbl.push_back(mk(0,0,16'h0,32'h0,       0,0, 1,20'h40008, 0,0,32'h0,   32'h0,       32'h33,     32'hDEADBEEF,1,0,0));
    tbl.push_back(mk(0,0,16'h0,32'h0,       0,0, 1,20'h3FFFC, 0,0,32'h0,   32'h0,       32'h0,      32'hDEADBEEF,1,0,1));
    tbl.push_back(mk(0,0,16'h0,32'h0,       0,0, 0,20'h0,     0,0,32'h0,   32'h0,       32'h0,      32'hDEADBEEF,1,0,1));
    tbl.push_back(mk(0,0,16'h0,32'h0,       0,0, 0,20'h0,     1,0,32'h1000,32'h0,       32'h0,      32'h0,       1,0,1));
    tbl.push_back(mk(0,0,16'h0,32'h0,       0,0, 0,20'h0,     0,1,32'h1010,32'h77,      32'h0,      32'h0,       1,0,1));
    tbl.push_back(mk(0,0,16'h0,32'h0,       0,0, 0,20'h0,     1,0,32'h10,  32'h0,       32'h0,      32'hDEADBEEF,1,0,1));
    tbl.push_back(mk(0,0,16'h0,32'h0,       0,1, 0,20'h0,     0,0,32'h0,   32'h0,       32'h0,      32'hDEADBEEF,0,1,0));
    tbl.push_back(mk(0,0,16'h0,32'h0,       0,0, 0,20'h0,     0,0,32'h0,   32'h0,       32'h0,      32'hDEADBEEF,0,1,0));
    tbl.push_back(mk(0,0,16'h0,32'h0,       0,0, 1,20'h40000, 1,0,32'h20,  32'h0,       32'h0,      32'hDEADBEEF,0,1,0));
    tbl.push_back(mk(0,0,16'h0,32'h0,       1,1, 0,20'h0,     0,0,32'h0,   32'h0,       32'h0,      32'hDEADBEEF,0,1,0));
    tbl.push_back(mk(0,0,16'h0,32'h0,       0,0, 0,20'h0,     0,0,32'h0,   32'h0,       32'h0,      32'hDEADBEEF,0,1,0));
    tbl.push_back(mk(0,0,16'h0,32'h0,       1,0, 0,20'h0,     0,0,32'h0,   32'h0,       32'h0,      32'hDEADBEEF,0,0,0));
    tbl.push_back(mk(0,0,16'h0,32'h0,       1,1, 0,20'h0,     0,0,32'h0,   32'h0,       32'h0,      32'hDEADBEEF,0,1,0));
    tbl.push_back(mk(0,0,16'h0,32'h0,       1,0, 0,20'h0,     0,0,32'h0,   32'h0,       32'h0,      32'hDEADBEEF,0,0,0));
    tbl.push_back(mk(0,0,16'h0,32'h0,       0,0, 0,20'h0,     0,0,32'h0,   32'h0,       32'h0,      32'hDEADBEEF,1,0,0));
    tbl.push_back(mk(0,0,16'h0,32'h0,       0,0, 1,20'h4000C, 0,0,32'h0,   32'h0,       32'h44,     32'hDEADBEEF,1,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      runVector($sformatf("v%0d", i), tbl[i]);
    end

    // Asynchronous reset in the middle of RUN: outputs clear before any clock edge.
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checkVector("midrun reset", zeroVec);
    @(negedge clk);
    rst_n = 1'b1;

    runVector("post-reset idle", mk(0,0,16'h0,32'h0, 0,0, 0,20'h0,     0,0,32'h0, 32'h0, 32'h0,  32'h0, 0,1,0));
    runVector("post-reset done", mk(0,0,16'h0,32'h0, 1,0, 0,20'h0,     0,0,32'h0, 32'h0, 32'h0,  32'h0, 0,0,0));
    runVector("post-reset run",  mk(0,0,16'h0,32'h0, 0,0, 0,20'h0,     0,0,32'h0, 32'h0, 32'h0,  32'h0, 1,0,0));
    runVector("imem survives",   mk(0,0,16'h0,32'h0, 0,0, 1,20'h40000, 0,0,32'h0, 32'h0, 32'h11, 32'h0, 1,0,0));
    runVector("dmem survives",   mk(0,0,16'h0,32'h0, 0,0, 0,20'h0,     1,0,32'h20,32'h0, 32'h11, 32'h9, 1,0,0));

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
